pd_sequencer: RTL and testbench
===============================

PD_SEQUENCER -- requirements
Module: pd_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, SHALL set the cycles from pwrGood high to isolation release (range 1..255).
REQ-002 Parameter ISO_CYCLES, default 2, SHALL set the cycles isolation is held before power-off (range 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum cycles spent waiting for pwrGood in either direction (range 1..1023).
REQ-004 ck  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 arst  input  1  reset; synchronous and active-high.
REQ-006 reqOn  input  3  requested power state per domain, level-sensitive; bit0=M1, bit1=M2, bit2=M3.
REQ-007 pwrGood  input  3  power-switch status per domain, same bit order; synchronous to ck.
REQ-008 pwrEn  output  3  power-switch enable per domain.
REQ-009 isolateM1 / isolateM2 / isolateM3  output  1 each  isolation clamp enable, 1 = clamp active.
REQ-010 domOn  output  3  1 when the domain is in state ON.
REQ-011 busy  output  1  1 while any domain is in a transitional state.
REQ-012 err  output  3  sticky per-domain pwrGood timeout flag.

Function
REQ-013 Each domain SHALL run its own FSM with states OFF, PWRUP, SETTLE, ON, ISO, PWRDN.
REQ-014 State outputs: OFF pwrEn=0 iso=1; PWRUP pwrEn=1 iso=1; SETTLE pwrEn=1 iso=1; ON pwrEn=1 iso=0; ISO pwrEn=1 iso=1; PWRDN pwrEn=0 iso=1. All outputs SHALL be registered.
REQ-015 Dependency: M1 SHALL never be outside OFF unless M2 and M3 are both ON (M1 is less on than M2/M3).
REQ-016 Effective target: M1 = reqOn[0]&reqOn[1]&reqOn[2]; M2 = reqOn[1]; M3 = reqOn[2].
REQ-017 Grants SHALL only be issued while busy=0, with at most one grant per cycle.
REQ-018 Grant priority: power-down before power-up; down order M1, M2, M3; up order M2, M3, M1.
REQ-019 M2/M3 power-down SHALL NOT be granted unless M1 is OFF.
REQ-020 M1 power-up SHALL NOT be granted unless M2 and M3 are both ON.
REQ-021 Up grant in cycle N SHALL make the state PWRUP with pwrEn=1 in cycle N+1.
REQ-022 PWRUP -> SETTLE on the first cycle pwrGood=1.
REQ-023 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> ON and iso deasserts.
REQ-024 Down grant in cycle N SHALL assert iso=1 (state ISO) in cycle N+1.
REQ-025 ISO SHALL last exactly ISO_CYCLES cycles, then -> PWRDN with pwrEn=0.
REQ-026 PWRDN -> OFF on the first cycle pwrGood=0.
REQ-027 A started transition SHALL complete regardless of reqOn changes; the new target is serviced by a later grant.
REQ-028 Timeout: if PWRUP or PWRDN persists TIMEOUT_CYCLES cycles, the domain SHALL set err and go to OFF (pwrEn=0, iso=1).
REQ-029 A domain with err=1 SHALL receive no up grant until reset.
REQ-030 busy SHALL be 1 whenever any domain is in PWRUP, SETTLE, ISO or PWRDN.
REQ-031 Isolation ordering: iso SHALL be 1 in every cycle where pwrEn=0 or pwrGood=0 for that domain.

Reset
REQ-032 While arst=1 at a ck edge, the next state SHALL be: all domains OFF, pwrEn=000, isolateM1/M2/M3=1, domOn=000, busy=0, err=000, all counters 0.
REQ-033 Reset asserted mid-transition SHALL abort the transition immediately, with no power-down sequencing.

Verification
REQ-034 Cold up: reset, reqOn=111, pwrGood follows pwrEn after 3 cycles -> power-up order M2, M3, M1; each iso release 4 cycles after its pwrGood rise; final domOn=111.
REQ-035 Dependency: from all ON, reqOn=101 (M2 off) -> M1 goes ISO, then PWRDN, then OFF before M2 enters ISO; domOn ends 100.
REQ-036 Premature M1: from reset, reqOn=001 -> no grant issued; pwrEn stays 000, busy=0.
REQ-037 Timeout: reqOn=010 with pwrGood held at 0 -> pwrEn[1]=1 for 64 cycles, then err=010, pwrEn=000, isolateM2=1; no further M2 grant.
REQ-038 Request change: reqOn[2] toggled 1->0 during M3 SETTLE -> M3 reaches ON, then ISO for 2 cycles, then PWRDN, then OFF.
REQ-039 Mid-op reset: arst pulsed during M2 ISO -> next cycle pwrEn=000, all iso=1, busy=0; REQ-031 checked every cycle by assertion.

Source files
------------

// File: rtl/pd_sequencer.sv
// Power-domain sequencer for three domains (M1 depends on M2 and M3).
// Grants one power-up or power-down at a time and only while no domain is in transition.
module pd_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned ISO_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       ck,
    input  logic       arst,
    input  logic [2:0] reqOn,
    input  logic [2:0] pwrGood,
    output logic [2:0] pwrEn,
    output logic       isolateM1,
    output logic       isolateM2,
    output logic       isolateM3,
    output logic [2:0] domOn,
    output logic       busy,
    output logic [2:0] err
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned N_DOM = 3;

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_PWRUP  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_ON     = 3'd3;
    localparam logic [2:0] ST_ISO    = 3'd4;
    localparam logic [2:0] ST_PWRDN  = 3'd5;

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ISO_LAST     = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [N_DOM-1:0][2:0]       state_q, state_d;
    logic [N_DOM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_DOM-1:0]            err_q, err_d;
    logic [N_DOM-1:0]            pwr_en_q, pwr_en_d;
    logic [N_DOM-1:0]            iso_q, iso_d;
    logic [N_DOM-1:0]            dom_on_q, dom_on_d;
    logic                        busy_q, busy_d;

    logic [N_DOM-1:0] target;
    logic [N_DOM-1:0] down_ok, up_ok;
    logic [N_DOM-1:0] grant_dn, grant_up;

    // Grant arbitration: downs (M1, M2, M3) beat ups (M2, M3, M1)
    always_comb begin
        target   = {reqOn[2], reqOn[1], &reqOn};
        down_ok  = '0;
        up_ok    = '0;
        grant_dn = '0;
        grant_up = '0;
        for (int i = 0; i < 3; i++) begin
            down_ok[i] = (state_q[i] == ST_ON) && !target[i];
            up_ok[i]   = (state_q[i] == ST_OFF) && target[i] && !err_q[i];
        end
        down_ok[1] = down_ok[1] && (state_q[0] == ST_OFF);
        down_ok[2] = down_ok[2] && (state_q[0] == ST_OFF);
        up_ok[0]   = up_ok[0] && (state_q[1] == ST_ON) && (state_q[2] == ST_ON);
        if (!busy_q) begin
            if (down_ok[0])      grant_dn = 3'b001;
            else if (down_ok[1]) grant_dn = 3'b010;
            else if (down_ok[2]) grant_dn = 3'b100;
            else if (up_ok[1])   grant_up = 3'b010;
            else if (up_ok[2])   grant_up = 3'b100;
            else if (up_ok[0])   grant_up = 3'b001;
        end
    end

    // Per-domain next state, counters and registered output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pwr_en_d = '0;
        iso_d    = '1;
        dom_on_d = '0;
        busy_d   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (state_q[i])
                ST_OFF: begin
                    if (grant_up[i]) begin
                        state_d[i] = ST_PWRUP;
                        cnt_d[i]   = '0;
                    end
                end
                ST_PWRUP: begin
                    if (pwrGood[i]) begin
                        state_d[i] = ST_SETTLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == TIMEOUT_LAST) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                        err_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q[i] == SETTLE_LAST) begin
                        state_d[i] = ST_ON;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (grant_dn[i]) begin
                        state_d[i] = ST_ISO;
                        cnt_d[i]   = '0;
                    end
                end
                ST_ISO: begin
                    if (cnt_q[i] == ISO_LAST) begin
                        state_d[i] = ST_PWRDN;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_PWRDN: begin
                    if (!pwrGood[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == TIMEOUT_LAST) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                        err_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = '0;
                end
            endcase
            pwr_en_d[i] = (state_d[i] == ST_PWRUP) || (state_d[i] == ST_SETTLE) ||
                          (state_d[i] == ST_ON)    || (state_d[i] == ST_ISO);
            iso_d[i]    = (state_d[i] != ST_ON);
            dom_on_d[i] = (state_d[i] == ST_ON);
            if ((state_d[i] != ST_OFF) && (state_d[i] != ST_ON)) busy_d = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (arst) begin
            state_q  <= {N_DOM{ST_OFF}};
            cnt_q    <= '0;
            err_q    <= '0;
            pwr_en_q <= '0;
            iso_q    <= '1;
            dom_on_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            pwr_en_q <= pwr_en_d;
            iso_q    <= iso_d;
            dom_on_q <= dom_on_d;
            busy_q   <= busy_d;
        end
    end

    assign pwrEn     = pwr_en_q;
    assign isolateM1 = iso_q[0];
    assign isolateM2 = iso_q[1];
    assign isolateM3 = iso_q[2];
    assign domOn     = dom_on_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pd_sequencer.sv
// Bench for pd_sequencer: directed scenarios plus randomized requests, checked
// every cycle against a countdown-style behavioural model and a power-switch plant.
module tb_pd_sequencer;

    localparam int SETTLE = 4;
    localparam int ISO    = 2;
    localparam int TMO    = 64;

    localparam int S_OFF = 0, S_UP = 1, S_SET = 2, S_ON = 3, S_ISO = 4, S_DN = 5;

    logic       ck = 1'b0;
    logic       arst = 1'b1;
    logic [2:0] reqOn = 3'b000;
    logic [2:0] pwrGood = 3'b000;
    logic [2:0] pwrEn;
    logic       isolateM1, isolateM2, isolateM3;
    logic [2:0] domOn;
    logic       busy;
    logic [2:0] err;

    always #5 ck = ~ck;

    pd_sequencer #(.SETTLE_CYCLES(SETTLE), .ISO_CYCLES(ISO), .TIMEOUT_CYCLES(TMO)) dut (
        .ck(ck), .arst(arst), .reqOn(reqOn), .pwrGood(pwrGood), .pwrEn(pwrEn),
        .isolateM1(isolateM1), .isolateM2(isolateM2), .isolateM3(isolateM3),
        .domOn(domOn), .busy(busy), .err(err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_st[3];
    int         m_rem[3];
    logic [2:0] m_err = 3'b000;
    bit         started = 0;

    task automatic model_step(input logic r, input logic [2:0] rq, input logic [2:0] pg);
        logic [2:0] tgt;
        bit         any_busy;
        int         gdom;
        bit         gup;
        int         order[3];
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_st[i]  = S_OFF;
                m_rem[i] = 0;
            end
            m_err = 3'b000;
            return;
        end
        order    = '{1, 2, 0};
        tgt      = {rq[2], rq[1], rq[0] & rq[1] & rq[2]};
        any_busy = 0;
        for (int i = 0; i < 3; i++)
            if (m_st[i] != S_OFF && m_st[i] != S_ON) any_busy = 1;
        gdom = -1;
        gup  = 0;
        if (!any_busy) begin
            for (int k = 0; k < 3; k++)
                if (gdom < 0 && m_st[k] == S_ON && !tgt[k] && (k == 0 || m_st[0] == S_OFF)) begin
                    gdom = k;
                    gup  = 0;
                end
            for (int j = 0; j < 3; j++) begin
                int k;
                k = order[j];
                if (gdom < 0 && m_st[k] == S_OFF && tgt[k] && !m_err[k] &&
                    (k != 0 || (m_st[1] == S_ON && m_st[2] == S_ON))) begin
                    gdom = k;
                    gup  = 1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            case (m_st[i])
                S_OFF: if (gdom == i && gup) begin m_st[i] = S_UP; m_rem[i] = TMO; end
                S_UP: begin
                    if (pg[i]) begin
                        m_st[i] = S_SET; m_rem[i] = SETTLE;
                    end else begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin m_st[i] = S_OFF; m_err[i] = 1'b1; end
                    end
                end
                S_SET: begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) m_st[i] = S_ON;
                end
                S_ON: if (gdom == i && !gup) begin m_st[i] = S_ISO; m_rem[i] = ISO; end
                S_ISO: begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin m_st[i] = S_DN; m_rem[i] = TMO; end
                end
                default: begin
                    if (!pg[i]) begin
                        m_st[i] = S_OFF;
                    end else begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin m_st[i] = S_OFF; m_err[i] = 1'b1; end
                    end
                end
            endcase
        end
    endtask

    function automatic logic [12:0] model_vec();
        logic [2:0] en, iso, on;
        bit b;
        b = 0;
        for (int i = 0; i < 3; i++) begin
            en[i]  = (m_st[i] == S_UP || m_st[i] == S_SET || m_st[i] == S_ON || m_st[i] == S_ISO);
            iso[i] = (m_st[i] != S_ON);
            on[i]  = (m_st[i] == S_ON);
            if (m_st[i] != S_OFF && m_st[i] != S_ON) b = 1;
        end
        return {en, iso, on, b, m_err};
    endfunction

    // Per-cycle compare against the model, plus the isolation-ordering rule
    initial begin
        logic r;
        logic [2:0] rq, pg, viol;
        forever begin
            @(posedge ck);
            r = arst; rq = reqOn; pg = pwrGood;
            model_step(r, rq, pg);
            if (r) started = 1;
            #1;
            if (started)
                check("outputs", {19'd0, pwrEn, isolateM3, isolateM2, isolateM1, domOn, busy, err},
                      {19'd0, model_vec()});
            #3;
            if (started) begin
                viol = (~pwrEn | ~pwrGood) & ~{isolateM3, isolateM2, isolateM1};
                check("iso_order", {29'd0, viol}, 32'd0);
            end
        end
    end

    // Power-switch plant: pwrGood follows pwrEn three cycles later unless stuck
    int pg_mode[3] = '{0, 0, 0};
    initial begin
        logic [2:0] d1, d2, d3;
        d1 = 0; d2 = 0; d3 = 0;
        forever begin
            @(posedge ck);
            #2;
            d3 = d2; d2 = d1; d1 = pwrEn;
            for (int i = 0; i < 3; i++)
                pwrGood[i] = (pg_mode[i] == 0) ? d3[i] : (pg_mode[i] == 2);
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
        cyc++;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int t_en[3], t_pg[3], t_on[3];
        int c0, n, cnt, t_m1_dn, t_m2_iso, iso_cnt;
        bit saw_on;
        logic [3:0] acc;

        step(); step();
        arst = 1'b0;
        check("rst_pwrEn", {29'd0, pwrEn}, 32'd0);
        check("rst_iso", {29'd0, isolateM3, isolateM2, isolateM1}, 32'd7);
        check("rst_domOn_busy_err", {25'd0, domOn, busy, err}, 32'd0);

        // premature M1 request
        reqOn = 3'b001;
        acc = 0;
        for (int i = 0; i < 20; i++) begin step(); acc = acc | {busy, pwrEn}; end
        check("premature_m1", {28'd0, acc}, 32'd0);

        // cold power-up
        for (int i = 0; i < 3; i++) begin t_en[i] = -1; t_pg[i] = -1; t_on[i] = -1; end
        c0 = cyc;
        reqOn = 3'b111;
        for (n = 0; n < 400 && domOn != 3'b111; n++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (pwrEn[i] && t_en[i] < 0) t_en[i] = cyc;
                if (pwrGood[i] && pwrEn[i] && t_pg[i] < 0) t_pg[i] = cyc;
                if (domOn[i] && t_on[i] < 0) t_on[i] = cyc;
            end
        end
        check("cold_domOn", {29'd0, domOn}, 32'd7);
        check("first_grant_latency", t_en[1], c0 + 1);
        check("up_order", {31'd0, (t_en[1] < t_en[2]) && (t_en[2] < t_en[0])}, 32'd1);
        for (int i = 0; i < 3; i++) check("iso_release", t_on[i] - t_pg[i], SETTLE);
        check("cold_busy", {31'd0, busy}, 32'd0);

        // M2 off with dependency
        t_m1_dn = -1; t_m2_iso = -1;
        reqOn = 3'b101;
        for (n = 0; n < 400 && !(domOn == 3'b100 && !busy); n++) begin
            step();
            if (!pwrEn[0] && t_m1_dn < 0) t_m1_dn = cyc;
            if (isolateM2 && t_m2_iso < 0) t_m2_iso = cyc;
        end
        check("dep_domOn", {29'd0, domOn}, 32'd4);
        check("dep_order", {31'd0, (t_m1_dn > 0) && (t_m1_dn < t_m2_iso)}, 32'd1);

        // request withdrawn during M3 settle
        reqOn = 3'b000;
        for (n = 0; n < 400 && !(domOn == 3'b000 && !busy); n++) step();
        check("all_off", {28'd0, domOn, busy}, 32'd0);
        reqOn = 3'b100;
        for (n = 0; n < 100 && !(pwrGood[2] && pwrEn[2]); n++) step();
        check("m3_settle_reached", {31'd0, pwrGood[2] & pwrEn[2]}, 32'd1);
        reqOn = 3'b000;
        saw_on = 0; iso_cnt = 0;
        for (n = 0; n < 200 && !(saw_on && !pwrEn[2]); n++) begin
            step();
            if (domOn[2]) saw_on = 1;
            if (saw_on && !domOn[2] && pwrEn[2]) iso_cnt++;
        end
        check("m3_reached_on", {31'd0, saw_on}, 32'd1);
        check("m3_iso_len", iso_cnt, ISO);
        for (n = 0; n < 100 && busy; n++) step();
        check("m3_off", {28'd0, domOn, busy}, 32'd0);

        // reset during M2 isolation
        reqOn = 3'b010;
        for (n = 0; n < 200 && !(domOn == 3'b010 && !busy); n++) step();
        reqOn = 3'b000;
        for (n = 0; n < 50 && !(isolateM2 && pwrEn[1]); n++) step();
        check("m2_iso_reached", {31'd0, isolateM2 & pwrEn[1]}, 32'd1);
        arst = 1'b1;
        step();
        arst = 1'b0;
        check("midreset", {25'd0, pwrEn, isolateM3, isolateM2, isolateM1, busy},
              {25'd0, 3'b000, 3'b111, 1'b0});

        // M2 power-good timeout
        pg_mode[1] = 1;
        step(); step(); step(); step();
        reqOn = 3'b010;
        cnt = 0;
        for (n = 0; n < 300 && err == 3'b000; n++) begin
            step();
            if (pwrEn[1]) cnt++;
        end
        check("tmo_len", cnt, TMO);
        check("tmo_err", {29'd0, err}, 32'd2);
        check("tmo_state", {28'd0, pwrEn, isolateM2}, 32'd1);
        acc = 0;
        for (int i = 0; i < 30; i++) begin step(); acc = acc | {busy, pwrEn}; end
        check("tmo_no_regrant", {28'd0, acc}, 32'd0);
        pg_mode[1] = 0;
        arst = 1'b1;
        step();
        arst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step();
            arst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) reqOn = 3'($urandom());
            for (int d = 0; d < 3; d++)
                if (m_st[d] == S_OFF && $urandom_range(0, 59) == 0)
                    pg_mode[d] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
        arst = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
